// File: rtl/audio_pll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pll_pkg
//  Description : Shared types, default timing constants and output decode
//                for the audio PLL sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pll_pkg;

    // Default timing for a 50 MHz reference clock
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 7;
    localparam int DEF_CNT_W         = 16;

    localparam int LOSS_W  = 8;
    localparam int RETRY_W = 4;
    localparam int STATE_W = 3;

    // Encodings are visible to software through the state status field
    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    typedef struct packed {
        logic pll_rst;
        logic clk_ready;
        logic domain_rst_n;
        logic fail;
    } pll_outs_t;

    // Level outputs as a pure function of state; the FSM registers this
    // value for the state it is entering so outputs move with the state.
    function automatic pll_outs_t decode_outs(input pll_state_t s);
        pll_outs_t o;
        o.pll_rst      = 1'b1;
        o.clk_ready    = 1'b0;
        o.domain_rst_n = 1'b0;
        o.fail         = 1'b0;
        case (s)
            ST_WAIT_LOCK, ST_SETTLE: begin
                o.pll_rst = 1'b0;
            end
            ST_RUN: begin
                o.pll_rst      = 1'b0;
                o.clk_ready    = 1'b1;
                o.domain_rst_n = 1'b1;
            end
            ST_FAIL: begin
                o.fail = 1'b1;
            end
            default: begin
                o.pll_rst = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_pll_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchronizer, async active-low reset,
//                resets to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pll_sequencer
//  Description : Pulses the audio PLL reset, waits for lock with timeout and
//                bounded retries, qualifies lock over a stability window and
//                then releases the audio-domain reset. Re-sequences on loss.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pll_sequencer
    import audio_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               clk_ready,
    output logic               domain_rst_n,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output logic [STATE_W-1:0] state
);

    // Counter reload values: the counter runs N-1 down to 0, i.e. N cycles
    localparam logic [CNT_W-1:0]   RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    pll_state_t cur_state;
    pll_outs_t  outs;
    logic [CNT_W-1:0] cnt;
    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Sequencer FSM with shared down-counter; outputs load on each transition
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_PLL_RST;
            cnt       <= RST_LOAD;
            outs      <= decode_outs(ST_PLL_RST);
            lock_lost <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (restart) begin
                // Restart wins over everything, including a coincident loss
                cur_state <= ST_PLL_RST;
                cnt       <= RST_LOAD;
                outs      <= decode_outs(ST_PLL_RST);
                retry_cnt <= '0;
            end else begin
                case (cur_state)
                    ST_PLL_RST: begin
                        if (cnt == '0) begin
                            cur_state <= ST_WAIT_LOCK;
                            cnt       <= TIMEOUT_LOAD;
                            outs      <= decode_outs(ST_WAIT_LOCK);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            cur_state <= ST_SETTLE;
                            cnt       <= STABLE_LOAD;
                            outs      <= decode_outs(ST_SETTLE);
                        end else if (cnt == '0) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            if (retry_cnt == RETRY_LAST) begin
                                cur_state <= ST_FAIL;
                                outs      <= decode_outs(ST_FAIL);
                            end else begin
                                cur_state <= ST_PLL_RST;
                                cnt       <= RST_LOAD;
                                outs      <= decode_outs(ST_PLL_RST);
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (!lock_s) begin
                            // Unstable lock is not a timeout: no retry charged
                            cur_state <= ST_WAIT_LOCK;
                            cnt       <= TIMEOUT_LOAD;
                            outs      <= decode_outs(ST_WAIT_LOCK);
                        end else if (cnt == '0) begin
                            cur_state <= ST_RUN;
                            outs      <= decode_outs(ST_RUN);
                            retry_cnt <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RUN: begin
                        retry_cnt <= '0;
                        if (!lock_s) begin
                            cur_state <= ST_PLL_RST;
                            cnt       <= RST_LOAD;
                            outs      <= decode_outs(ST_PLL_RST);
                            lock_lost <= 1'b1;
                            if (loss_cnt != '1) begin
                                loss_cnt <= loss_cnt + 1'b1;
                            end
                        end
                    end
                    ST_FAIL: begin
                        cur_state <= ST_FAIL;
                    end
                    default: begin
                        cur_state <= ST_PLL_RST;
                        cnt       <= RST_LOAD;
                        outs      <= decode_outs(ST_PLL_RST);
                    end
                endcase
            end
        end
    end

    assign pll_rst      = outs.pll_rst;
    assign clk_ready    = outs.clk_ready;
    assign domain_rst_n = outs.domain_rst_n;
    assign fail         = outs.fail;
    assign state        = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_audio_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_pll_sequencer
//  Description : Directed self-checking bench for audio_pll_sequencer with
//                small timing parameters and hand-computed edge numbers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pll_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       pll_locked;
    logic       pll_rst;
    logic       clk_ready;
    logic       domain_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int lat;

    audio_pll_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .CNT_W         (16)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .restart      (restart),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .clk_ready    (clk_ready),
        .domain_rst_n (domain_rst_n),
        .lock_lost    (lock_lost),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt),
        .state        (state)
    );

    // 50 MHz reference clock
    always #10 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Advance one rising edge; inputs driven and outputs sampled 1 ns later
    task automatic tick();
        @(posedge refclk);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!clk_ready && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(state),        32'd0);
        check({tag, "_pllrst"}, 32'(pll_rst),      32'd1);
        check({tag, "_ready"},  32'(clk_ready),    32'd0);
        check({tag, "_drstn"},  32'(domain_rst_n), 32'd0);
        check({tag, "_lost"},   32'(lock_lost),    32'd0);
        check({tag, "_fail"},   32'(fail),         32'd0);
        check({tag, "_retry"},  32'(retry_cnt),    32'd0);
        check({tag, "_loss"},   32'(loss_cnt),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n      = 1'b0;
        restart    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge refclk);
        #3;
        check_reset_vals("rst");

        // ---- Nominal lock: pll_locked driven after edge 10, RUN at edge 21
        @(negedge refclk);
        rst_n  = 1'b1;
        edge_n = 0;
        tick_to(3);
        check("nom_pllrst_e3", 32'(pll_rst), 32'd1);
        tick_to(4);
        check("nom_pllrst_e4", 32'(pll_rst), 32'd0);
        check("nom_state_e4",  32'(state),   32'd1);
        tick_to(10);
        pll_locked = 1'b1;
        tick_to(20);
        check("nom_state_e20", 32'(state),     32'd2);
        check("nom_ready_e20", 32'(clk_ready), 32'd0);
        tick_to(21);
        check("nom_ready_e21", 32'(clk_ready),    32'd1);
        check("nom_drstn_e21", 32'(domain_rst_n), 32'd1);
        check("nom_state_e21", 32'(state),        32'd3);
        check("nom_retry",     32'(retry_cnt),    32'd0);

        // ---- Lock loss in RUN: drop after edge k, detected on edge k+3
        tick_to(23);
        k = edge_n;
        pll_locked = 1'b0;
        tick_to(k + 2);
        check("loss_drstn_k2", 32'(domain_rst_n), 32'd1);
        tick_to(k + 3);
        check("loss_drstn_k3", 32'(domain_rst_n), 32'd0);
        check("loss_pulse",    32'(lock_lost),    32'd1);
        check("loss_cnt1",     32'(loss_cnt),     32'd1);
        check("loss_state",    32'(state),        32'd0);
        check("loss_pllrst",   32'(pll_rst),      32'd1);
        pll_locked = 1'b1;
        tick_to(k + 4);
        check("loss_pulse_end", 32'(lock_lost), 32'd0);
        tick_to(k + 6);
        check("loss_pllrst_k6", 32'(pll_rst), 32'd1);
        tick_to(k + 7);
        check("loss_pllrst_k7", 32'(pll_rst), 32'd0);
        wait_ready(40, lat);
        check("relock_lat", 32'(lat),   32'd9);
        check("relock_run", 32'(state), 32'd3);

        // ---- Restart coincident with lock_s falling in RUN
        tick();
        k = edge_n;
        pll_locked = 1'b0;
        tick_to(k + 2);
        restart = 1'b1;
        tick_to(k + 3);
        restart = 1'b0;
        check("rs_state",  32'(state),     32'd0);
        check("rs_lost",   32'(lock_lost), 32'd0);
        check("rs_loss",   32'(loss_cnt),  32'd1);
        check("rs_pllrst", 32'(pll_rst),   32'd1);
        check("rs_ready",  32'(clk_ready), 32'd0);

        // ---- Settle glitch: high 5, low 1, high again (R = restart edge)
        k = edge_n;
        tick_to(k + 5);
        pll_locked = 1'b1;
        tick_to(k + 10);
        pll_locked = 1'b0;
        tick_to(k + 11);
        pll_locked = 1'b1;
        tick_to(k + 12);
        check("gl_settle",   32'(state),     32'd2);
        tick_to(k + 13);
        check("gl_abort",    32'(state),     32'd1);
        check("gl_retry",    32'(retry_cnt), 32'd0);
        wait_ready(40, lat);
        check("gl_ready_lat", 32'(lat),      32'd9);
        check("gl_loss",      32'(loss_cnt), 32'd1);

        // ---- Async reset mid-SETTLE, lock held through a restart
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        k = edge_n;
        tick_to(k + 5);
        check("ar_settle", 32'(state), 32'd2);
        #2;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        #1;
        check_reset_vals("ar");

        // ---- Lock timeout after release: retries at edges 24, 48, FAIL at 72
        @(negedge refclk);
        rst_n  = 1'b1;
        edge_n = 0;
        tick_to(3);
        check("to_pllrst_e3", 32'(pll_rst), 32'd1);
        tick_to(4);
        check("to_state_e4",  32'(state),   32'd1);
        tick_to(23);
        check("to_retry_e23", 32'(retry_cnt), 32'd0);
        tick_to(24);
        check("to_retry_e24", 32'(retry_cnt), 32'd1);
        check("to_state_e24", 32'(state),     32'd0);
        tick_to(48);
        check("to_retry_e48", 32'(retry_cnt), 32'd2);
        tick_to(71);
        check("to_state_e71", 32'(state), 32'd1);
        check("to_fail_e71",  32'(fail),  32'd0);
        tick_to(72);
        check("to_state_e72",  32'(state),     32'd4);
        check("to_fail_e72",   32'(fail),      32'd1);
        check("to_pllrst_e72", 32'(pll_rst),   32'd1);
        check("to_retry_e72",  32'(retry_cnt), 32'd3);
        tick_to(82);
        check("to_hold_state", 32'(state), 32'd4);
        check("to_hold_fail",  32'(fail),  32'd1);
        check("to_hold_drstn", 32'(domain_rst_n), 32'd0);

        // ---- Restart out of FAIL
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rf_state",  32'(state),     32'd0);
        check("rf_fail",   32'(fail),      32'd0);
        check("rf_retry",  32'(retry_cnt), 32'd0);
        check("rf_pllrst", 32'(pll_rst),   32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
